jtcontra_gfx_romarb: RTL and testbench

- Shares the single graphics-ROM SDRAM port of one 007121 instance between two requesters: the tilemap fetcher and the object (sprite) fetcher.
- Both requesters use the same cs/addr/ok/data handshake that the SDRAM slot expects.
- During active video the tilemap has priority, with a starvation guard for objects. During horizontal blank the objects have priority.
- Sits between the gfx tilemap/object engines and the jtframe SDRAM slot.

---
 rtl/jtcontra_gfx_romarb.sv | 221 ++++++++++++++++++++++
 tb/tb_jtcontra_gfx_romarb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_gfx_romarb.sv
// jtcontra_gfx_romarb
// Shares one 007121 graphics-ROM SDRAM slot between the tilemap fetcher and
// the object fetcher. In active video the tilemap has priority, and a
// saturating wait counter forces a starved object request through. In
// horizontal blank the objects have priority.
//
// Build macro JTCONTRA_GFXARB_RR_EN: when defined, active-video arbitration
// alternates between tile and obj after every completed access instead of
// using tile priority with the wait counter. Blanking behaviour is the same.
module jtcontra_gfx_romarb #(
  parameter int AW           = 18,
  parameter int DW           = 16,
  parameter int OBJ_MAX_WAIT = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          LHBL,
  input  logic          tile_cs,
  input  logic [AW-1:0] tile_addr,
  output logic          tile_ok,
  output logic [DW-1:0] tile_data,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic          obj_ok,
  output logic [DW-1:0] obj_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ok,
  input  logic [DW-1:0] rom_data,
  output logic          grant_obj
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;

  // Address each requester was last served at; its ok holds while it matches
  logic [AW-1:0] tile_lat_r;
  logic [AW-1:0] tile_lat_s;
  logic [AW-1:0] obj_lat_r;
  logic [AW-1:0] obj_lat_s;

  logic          rom_cs_s;
  logic [AW-1:0] rom_addr_s;
  logic          grant_obj_s;
  logic          tile_ok_s;
  logic          obj_ok_s;
  logic [DW-1:0] tile_data_s;
  logic [DW-1:0] obj_data_s;

  logic          tile_pend_s;
  logic          obj_pend_s;
  logic          obj_win_s;
  logic          owner_hold_s;

`ifdef JTCONTRA_GFXARB_RR_EN
  logic          rr_obj_r;
  logic          rr_obj_s;
`else
  localparam logic [3:0] WAIT_MAX = 4'(OBJ_MAX_WAIT);
  logic [3:0]    wait_cnt_r;
  logic [3:0]    wait_cnt_s;
`endif

  // Pending requests, the winner IDLE would pick, and whether the owner still holds its request
  always_comb begin
    tile_pend_s = tile_cs & ~tile_ok;
    obj_pend_s  = obj_cs & ~obj_ok;
    obj_win_s   = 1'b0;
    if (!LHBL || !tile_pend_s) begin
      // blanking favours obj; a lone requester always wins
      obj_win_s = obj_pend_s;
    end else if (!obj_pend_s) begin
      obj_win_s = 1'b0;
    end else begin
`ifdef JTCONTRA_GFXARB_RR_EN
      obj_win_s = rr_obj_r;
`else
      obj_win_s = (wait_cnt_r == WAIT_MAX);
`endif
    end
    if (grant_obj) begin
      owner_hold_s = obj_cs & (obj_addr == rom_addr);
    end else begin
      owner_hold_s = tile_cs & (tile_addr == rom_addr);
    end
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_s     = state_r;
    rom_cs_s    = 1'b0;
    rom_addr_s  = rom_addr;
    grant_obj_s = grant_obj;
    tile_data_s = tile_data;
    obj_data_s  = obj_data;
    tile_lat_s  = tile_lat_r;
    obj_lat_s   = obj_lat_r;
    // ok is a level: it survives only while cs and the served address persist
    tile_ok_s   = tile_ok & tile_cs & (tile_addr == tile_lat_r);
    obj_ok_s    = obj_ok & obj_cs & (obj_addr == obj_lat_r);
    case (state_r)
      IDLE: begin
        if (tile_pend_s || obj_pend_s) begin
          state_s     = SERVE;
          rom_cs_s    = 1'b1;
          grant_obj_s = obj_win_s;
          rom_addr_s  = obj_win_s ? obj_addr : tile_addr;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE: begin
        if (!owner_hold_s) begin
          // owner went away or moved: abort, no data, no ok
          state_s = RELEASE;
        end else if (rom_ok) begin
          state_s = RELEASE;
          if (grant_obj) begin
            obj_data_s = rom_data;
            obj_ok_s   = 1'b1;
            obj_lat_s  = rom_addr;
          end else begin
            tile_data_s = rom_data;
            tile_ok_s   = 1'b1;
            tile_lat_s  = rom_addr;
          end
        end else begin
          rom_cs_s = 1'b1;
        end
      end
      RELEASE: begin
        // one cycle with rom_cs low so the slot sees a fresh request
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef JTCONTRA_GFXARB_RR_EN
  // Round-robin preference flips to the other requester after each completed access
  always_comb begin
    rr_obj_s = rr_obj_r;
    if (state_r == SERVE && owner_hold_s && rom_ok) begin
      rr_obj_s = ~grant_obj;
    end else begin
      rr_obj_s = rr_obj_r;
    end
  end
`else
  // Object starvation counter: counts refused active-video cycles, saturating
  always_comb begin
    wait_cnt_s = wait_cnt_r;
    if (!obj_cs) begin
      wait_cnt_s = 4'd0;
    end else if (state_r == IDLE && obj_win_s) begin
      wait_cnt_s = 4'd0;
    end else if (LHBL && obj_pend_s && !(state_r == SERVE && grant_obj)
                 && wait_cnt_r != WAIT_MAX) begin
      wait_cnt_s = wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_s = wait_cnt_r;
    end
  end
`endif

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      grant_obj  <= 1'b0;
      tile_ok    <= 1'b0;
      obj_ok     <= 1'b0;
      tile_data  <= '0;
      obj_data   <= '0;
      tile_lat_r <= '0;
      obj_lat_r  <= '0;
    end else begin
      state_r    <= state_s;
      rom_cs     <= rom_cs_s;
      rom_addr   <= rom_addr_s;
      grant_obj  <= grant_obj_s;
      tile_ok    <= tile_ok_s;
      obj_ok     <= obj_ok_s;
      tile_data  <= tile_data_s;
      obj_data   <= obj_data_s;
      tile_lat_r <= tile_lat_s;
      obj_lat_r  <= obj_lat_s;
    end
  end

`ifdef JTCONTRA_GFXARB_RR_EN
  // Round-robin preference register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_obj_r <= 1'b0;
    end else begin
      rr_obj_r <= rr_obj_s;
    end
  end
`else
  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else begin
      wait_cnt_r <= wait_cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// Randomized bench for jtcontra_gfx_romarb: an access-level reference model
// (one in-flight access, a one-cycle gap after it, priority rules) predicts
// every output each cycle; a small SDRAM model answers with data derived
// from the address.
module tb_jtcontra_gfx_romarb;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int OBJ_MAX_WAIT = 8;

  logic          rst, clk, LHBL;
  logic          tile_cs, obj_cs, rom_ok;
  logic [AW-1:0] tile_addr, obj_addr, rom_addr;
  logic [DW-1:0] tile_data, obj_data, rom_data;
  logic          tile_ok, obj_ok, rom_cs, grant_obj;

  int n_vec = 0;
  int n_err = 0;
  int n;

  // reference model
  logic          m_busy, m_cool, m_owner, m_tok, m_ook, m_rr;
  logic [AW-1:0] m_addr, m_tlat, m_olat;
  logic [DW-1:0] m_tdata, m_odata;
  int            m_wait;

  // SDRAM model
  int sd_cnt, sd_lat;
  bit spur_en;
  int starve, starve_max;

  jtcontra_gfx_romarb #(.AW(AW), .DW(DW), .OBJ_MAX_WAIT(OBJ_MAX_WAIT)) dut (
    .rst(rst), .clk(clk), .LHBL(LHBL),
    .tile_cs(tile_cs), .tile_addr(tile_addr), .tile_ok(tile_ok), .tile_data(tile_data),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
    .grant_obj(grant_obj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hACDB ^ {14'd0, a[17:16]};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom_range(0, 3) == 0) a = a & 18'h00007;
    return a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_cool = 1'b0; m_owner = 1'b0; m_tok = 1'b0; m_ook = 1'b0;
    m_rr = 1'b0; m_addr = '0; m_tlat = '0; m_olat = '0; m_tdata = '0; m_odata = '0;
    m_wait = 0;
  endtask

  // One clock edge of the reference model, using the inputs held across it
  task automatic model_step();
    logic tp, op, own_ok, win_obj, gnt_obj, was_obj_serve, n_tok, n_ook;
    tp = tile_cs && !m_tok;
    op = obj_cs && !m_ook;
    n_tok = m_tok && tile_cs && (tile_addr == m_tlat);
    n_ook = m_ook && obj_cs && (obj_addr == m_olat);
    was_obj_serve = m_busy && m_owner;
    gnt_obj = 1'b0;
    if (m_busy) begin
      own_ok = m_owner ? (obj_cs && obj_addr == m_addr) : (tile_cs && tile_addr == m_addr);
      if (!own_ok || rom_ok) begin
        m_busy = 1'b0;
        m_cool = 1'b1;
        if (own_ok) begin
          if (m_owner) begin
            n_ook = 1'b1; m_olat = m_addr; m_odata = mem_f(m_addr);
          end else begin
            n_tok = 1'b1; m_tlat = m_addr; m_tdata = mem_f(m_addr);
          end
          m_rr = !m_owner;
        end
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (tp || op) begin
      if (!LHBL || !tp) win_obj = op;
      else if (!op) win_obj = 1'b0;
      else begin
`ifdef JTCONTRA_GFXARB_RR_EN
        win_obj = m_rr;
`else
        win_obj = (m_wait >= OBJ_MAX_WAIT);
`endif
      end
      m_busy = 1'b1;
      m_owner = win_obj;
      m_addr = win_obj ? obj_addr : tile_addr;
      gnt_obj = win_obj;
    end
    if (!obj_cs || gnt_obj) m_wait = 0;
    else if (LHBL && op && !was_obj_serve && m_wait < OBJ_MAX_WAIT) m_wait++;
    m_tok = n_tok;
    m_ook = n_ook;
  endtask

  task automatic compare_all();
    check_eq("rom_cs", 32'(rom_cs), 32'(m_busy));
    check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    check_eq("grant_obj", 32'(grant_obj), 32'(m_owner));
    check_eq("tile_ok", 32'(tile_ok), 32'(m_tok));
    check_eq("obj_ok", 32'(obj_ok), 32'(m_ook));
    check_eq("tile_data", 32'(tile_data), 32'(m_tdata));
    check_eq("obj_data", 32'(obj_data), 32'(m_odata));
  endtask

  // SDRAM answers sd_lat cycles into a request with data for the presented address
  task automatic drive_sdram();
    if (rom_cs) begin
      sd_cnt++;
      rom_ok = (sd_cnt == sd_lat);
    end else begin
      sd_cnt = 0;
      rom_ok = spur_en && ($urandom_range(0, 9) == 0);
    end
    rom_data = rom_ok ? mem_f(rom_addr) : DW'($urandom);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive_sdram();
  endtask

  task automatic next_req(input logic cs, input logic [AW-1:0] a, input logic ok,
                          input int renew_pct, output logic ncs, output logic [AW-1:0] na);
    int r;
    ncs = cs; na = a;
    r = $urandom_range(0, 99);
    if (!cs) begin
      if (r < 30) begin ncs = 1'b1; na = rand_addr(); end
    end else if (ok) begin
      if (r < renew_pct) na = rand_addr();
      else if (r < renew_pct + 30) ncs = 1'b0;
    end else if (r < 3) begin
      if ($urandom_range(0, 1) == 0) ncs = 1'b0;
      else na = rand_addr();
    end
  endtask

  task automatic random_phase(input int cycles, input bit fix_video, input int tile_renew);
    logic ncs;
    logic [AW-1:0] na;
    for (int i = 0; i < cycles; i++) begin
      if (fix_video) LHBL = 1'b1;
      else if ($urandom_range(0, 19) == 0) LHBL = ~LHBL;
      next_req(tile_cs, tile_addr, m_tok, tile_renew, ncs, na);
      tile_cs = ncs; tile_addr = na;
      next_req(obj_cs, obj_addr, m_ook, 30, ncs, na);
      obj_cs = ncs; obj_addr = na;
      if (!rom_cs) sd_lat = $urandom_range(1, 5);
      cycle();
      if (LHBL && obj_cs && !m_ook && !(m_busy && m_owner)) starve++;
      else starve = 0;
      if (fix_video && starve > starve_max) starve_max = starve;
    end
  endtask

  initial begin
    rst = 1'b1; LHBL = 1'b1; tile_cs = 1'b0; obj_cs = 1'b0; rom_ok = 1'b0;
    tile_addr = '0; obj_addr = '0; rom_data = '0;
    sd_cnt = 0; sd_lat = 4; spur_en = 1'b0; starve = 0; starve_max = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // single tile request, SDRAM latency 4
    tile_addr = 18'h01234; tile_cs = 1'b1;
    cycle();
    check_eq("t1_rom_cs", 32'(rom_cs), 32'd1);
    check_eq("t1_rom_addr", 32'(rom_addr), 32'h01234);
    for (n = 0; n < 20 && !tile_ok; n++) cycle();
    check_eq("t1_latency", 32'(n), 32'd4);
    check_eq("t1_data", 32'(tile_data), 32'h0000BEEF);
    check_eq("t1_release", 32'(rom_cs), 32'd0);
    cycle();
    check_eq("t1_no_regrant", 32'(rom_cs), 32'd0);
    tile_cs = 1'b0;
    repeat (3) cycle();

    // blanking contention: obj first, tile next
    LHBL = 1'b0; sd_lat = 2;
    tile_addr = 18'h00AAA; tile_cs = 1'b1;
    obj_addr = 18'h20555; obj_cs = 1'b1;
    cycle();
    check_eq("blank_first_obj", 32'(grant_obj), 32'd1);
    for (n = 0; n < 20 && !obj_ok; n++) cycle();
    check_eq("blank_obj_ok", 32'(obj_ok), 32'd1);
    for (n = 0; n < 20 && !rom_cs; n++) cycle();
    check_eq("blank_then_tile", 32'(grant_obj), 32'd0);
    for (n = 0; n < 20 && !tile_ok; n++) cycle();
    check_eq("blank_tile_data", 32'(tile_data), 32'(mem_f(18'h00AAA)));
    tile_cs = 1'b0; obj_cs = 1'b0;
    repeat (3) cycle();

    // obj abort before rom_ok, then a normal tile access
    sd_lat = 10;
    obj_addr = 18'h10F0F; obj_cs = 1'b1;
    cycle();
    check_eq("abort_granted", 32'(grant_obj), 32'd1);
    cycle();
    obj_cs = 1'b0;
    cycle();
    check_eq("abort_rom_cs", 32'(rom_cs), 32'd0);
    check_eq("abort_obj_data", 32'(obj_data), 32'(mem_f(18'h20555)));
    LHBL = 1'b1; sd_lat = 3;
    tile_addr = 18'h00321; tile_cs = 1'b1;
    for (n = 0; n < 20 && !tile_ok; n++) cycle();
    check_eq("abort_tile_data", 32'(tile_data), 32'(mem_f(18'h00321)));
    tile_cs = 1'b0;
    repeat (3) cycle();

    // asynchronous reset in the middle of an access
    sd_lat = 10;
    tile_addr = 18'h00777; tile_cs = 1'b1;
    cycle();
    cycle();
    check_eq("rst_pre_cs", 32'(rom_cs), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rom_cs", 32'(rom_cs), 32'd0);
    check_eq("rst_tile_ok", 32'(tile_ok), 32'd0);
    check_eq("rst_obj_ok", 32'(obj_ok), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    model_reset();
    rom_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; sd_cnt = 0; sd_lat = 2;
    compare_all();
    for (n = 0; n < 20 && !tile_ok; n++) cycle();
    check_eq("rst_fresh_tile", 32'(tile_data), 32'(mem_f(18'h00777)));
    tile_cs = 1'b0;
    repeat (3) cycle();

    // active video, tile re-requesting aggressively: obj must not starve
    spur_en = 1'b1;
    random_phase(800, 1'b1, 70);
    check_eq("obj_starve_bound", 32'(starve_max <= 16), 32'd1);

    // fully random traffic
    random_phase(3000, 1'b0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
